// File: rtl/gshare_bpu_if.sv
// Fetch/execute side bundle of the gshare predictor: predict request/response,
// resolved-branch update and status/performance outputs.
interface gshare_bpu_if #(
   parameter int PC_W     = 32,
   parameter int GHR_BITS = 8,
   parameter int PERF_W   = 16
);
   logic                req_valid;
   logic                req_ready;
   logic [PC_W-1:0]     req_pc;
   logic                req_is_br;
   logic                req_is_jmp;

   logic                pred_valid;
   logic                pred_taken;
   logic [GHR_BITS-1:0] pred_ghr;

   logic                upd_valid;
   logic [PC_W-1:0]     upd_pc;
   logic [GHR_BITS-1:0] upd_ghr;
   logic                upd_taken;
   logic                upd_mispredict;

   logic                init_done;
   logic [PERF_W-1:0]   perf_br;
   logic [PERF_W-1:0]   perf_miss;

   modport master (
      output req_valid, req_pc, req_is_br, req_is_jmp,
      output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
      input  req_ready, pred_valid, pred_taken, pred_ghr,
      input  init_done, perf_br, perf_miss
   );

   modport slave (
      input  req_valid, req_pc, req_is_br, req_is_jmp,
      input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
      output req_ready, pred_valid, pred_taken, pred_ghr,
      output init_done, perf_br, perf_miss
   );
endinterface

// File: rtl/gshare_bpu.sv
// Parametrised gshare predictor: speculative GHR with checkpoint recovery,
// post-reset table sweep to weakly-not-taken, saturating perf counters.
module gshare_bpu #(
   parameter int PC_W     = 32,
   parameter int IDX_BITS = 8,
   parameter int GHR_BITS = 8,
   parameter int CTR_BITS = 2,
   parameter int PERF_W   = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   gshare_bpu_if.slave io_bus
);
   localparam int ENTRIES = 1 << IDX_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [PERF_W-1:0]   PERF_MAX = '1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              r_state;
   logic [IDX_BITS-1:0] r_sweep_idx;
   logic [GHR_BITS-1:0] r_ghr;
   logic                r_init_done;
   logic                r_pred_valid;
   logic                r_pred_taken;
   logic [GHR_BITS-1:0] r_pred_ghr;
   logic [PERF_W-1:0]   r_perf_br;
   logic [PERF_W-1:0]   r_perf_miss;
   logic [CTR_BITS-1:0] r_table [ENTRIES];

   logic                w_recover;
   logic                w_req_ready;
   logic                w_accept;
   logic [IDX_BITS-1:0] w_idx_p;
   logic [IDX_BITS-1:0] w_idx_u;
   logic                w_pred_dir;
   logic                w_pred_taken_next;
   logic [CTR_BITS-1:0] w_ctr_u;
   logic [CTR_BITS-1:0] w_ctr_next;
   logic [GHR_BITS-1:0] w_spec_ghr;
   logic [GHR_BITS-1:0] w_rec_ghr;
   logic                w_tab_we;
   logic [IDX_BITS-1:0] w_tab_waddr;
   logic [CTR_BITS-1:0] w_tab_wdata;
   logic                w_unused;

   // Recovery owns the cycle: no speculative shift can collide with it.
   assign w_recover   = io_bus.upd_valid && io_bus.upd_mispredict;
   assign w_req_ready = (r_state == ST_RUN) && !w_recover;
   assign w_accept    = io_bus.req_valid && w_req_ready;

   assign w_idx_p = io_bus.req_pc[IDX_BITS+1:2] ^ IDX_BITS'(r_ghr);
   assign w_idx_u = io_bus.upd_pc[IDX_BITS+1:2] ^ IDX_BITS'(io_bus.upd_ghr);

   assign w_pred_dir        = r_table[w_idx_p][CTR_BITS-1];
   assign w_pred_taken_next = io_bus.req_is_jmp || (io_bus.req_is_br && w_pred_dir);
   assign w_spec_ghr        = GHR_BITS'({r_ghr, w_pred_dir});
   assign w_rec_ghr         = GHR_BITS'({io_bus.upd_ghr, io_bus.upd_taken});

   assign w_ctr_u = r_table[w_idx_u];

   always_comb begin
      w_ctr_next = w_ctr_u;
      if (io_bus.upd_taken) begin
         if (w_ctr_u != CTR_MAX) w_ctr_next = w_ctr_u + 1'b1;
      end else if (w_ctr_u != '0) begin
         w_ctr_next = w_ctr_u - 1'b1;
      end
   end

   // Single write port: the sweep owns it in INIT, resolved branches in RUN.
   always_comb begin
      w_tab_we    = 1'b0;
      w_tab_waddr = r_sweep_idx;
      w_tab_wdata = CTR_INIT;
      if (r_state == ST_INIT) begin
         w_tab_we = 1'b1;
      end else if (io_bus.upd_valid) begin
         w_tab_we    = 1'b1;
         w_tab_waddr = w_idx_u;
         w_tab_wdata = w_ctr_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_tab_we) r_table[w_tab_waddr] <= w_tab_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_INIT;
         r_sweep_idx  <= '0;
         r_ghr        <= '0;
         r_init_done  <= 1'b0;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_ghr   <= '0;
         r_perf_br    <= '0;
         r_perf_miss  <= '0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_pred_valid <= 1'b0;
               r_sweep_idx  <= r_sweep_idx + 1'b1;
               if (&r_sweep_idx) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            ST_RUN: begin
               r_pred_valid <= w_accept;
               if (w_accept) begin
                  r_pred_taken <= w_pred_taken_next;
                  r_pred_ghr   <= r_ghr;
               end
               if (w_recover) begin
                  r_ghr <= w_rec_ghr;
               end else if (w_accept && io_bus.req_is_br && !io_bus.req_is_jmp) begin
                  r_ghr <= w_spec_ghr;
               end
               if (io_bus.upd_valid) begin
                  if (r_perf_br != PERF_MAX) r_perf_br <= r_perf_br + 1'b1;
                  if (io_bus.upd_mispredict && (r_perf_miss != PERF_MAX))
                     r_perf_miss <= r_perf_miss + 1'b1;
               end
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

   assign io_bus.req_ready  = w_req_ready;
   assign io_bus.pred_valid = r_pred_valid;
   assign io_bus.pred_taken = r_pred_taken;
   assign io_bus.pred_ghr   = r_pred_ghr;
   assign io_bus.init_done  = r_init_done;
   assign io_bus.perf_br    = r_perf_br;
   assign io_bus.perf_miss  = r_perf_miss;

   // PC bits outside the index field do not take part in prediction.
   assign w_unused = ^{io_bus.req_pc[PC_W-1:IDX_BITS+2], io_bus.req_pc[1:0],
                       io_bus.upd_pc[PC_W-1:IDX_BITS+2], io_bus.upd_pc[1:0]};
endmodule

// File: doc/gshare_bpu.md
Name: gshare_bpu

Overview:
Parametrised gshare conditional-branch predictor for the fetch stage. It generalises the 8-bit fixed predictor in four ways: configurable table, history and counter widths; a speculative GHR with checkpoint and mispredict recovery; a sequential table-init sweep after reset; and saturating performance counters. Fetch issues predict requests and receives a registered prediction plus a GHR checkpoint. Execute returns the resolved outcome with that checkpoint.

Parameters:
PC_W, 32, PC width.
IDX_BITS, 8, log2 of table entries; index source is pc[IDX_BITS+1:2].
GHR_BITS, 8, global history length; must be <= IDX_BITS.
CTR_BITS, 2, saturating counter width; must be >= 2.
PERF_W, 16, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
req_valid  in  1  predict request this cycle.
req_ready  out  1  request accepted when req_valid && req_ready.
req_pc  in  PC_W  PC of the fetched instruction.
req_is_br  in  1  conditional branch.
req_is_jmp  in  1  JAL/JALR (unconditional jump).
pred_valid  out  1  prediction valid, 1 cycle after acceptance.
pred_taken  out  1  predicted direction.
pred_ghr  out  GHR_BITS  GHR value before this request's speculative shift (checkpoint).
upd_valid  in  1  resolved conditional branch.
upd_pc  in  PC_W  PC of the resolved branch.
upd_ghr  in  GHR_BITS  checkpoint returned with the branch.
upd_taken  in  1  actual outcome.
upd_mispredict  in  1  outcome differed from the prediction.
init_done  out  1  table sweep complete.
perf_br  out  PERF_W  count of resolved branches.
perf_miss  out  PERF_W  count of mispredicts.

Behaviour:
- Reset (rst=0, async): FSM=INIT, sweep index=0, GHR=0, req_ready=0, pred_valid=0, pred_taken=0, pred_ghr=0, init_done=0, perf_br=0, perf_miss=0.
- INIT: writes one entry per cycle with the weakly-not-taken value 2^(CTR_BITS-1)-1 (2'b01 at default). After the last entry, 2^IDX_BITS-1, it goes to RUN and sets init_done=1. The sweep therefore takes 2^IDX_BITS cycles. upd_valid is ignored in INIT; perf counters do not change.
- RUN: req_ready=1, except in a cycle with upd_valid && upd_mispredict, where req_ready=0 (recovery has priority).
- Index: idx = pc[IDX_BITS+1:2] XOR zero-extended history.
  - Predict path uses the current speculative GHR.
  - Update path uses upd_ghr.
- Accepted request (1-cycle latency, registered outputs):
  - pred_valid=1 and pred_ghr=GHR in the next cycle.
  - req_is_jmp: pred_taken=1; GHR unchanged; table not read.
  - req_is_br: pred_taken = MSB of table[idx]; GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
  - Neither flag set: pred_taken=0; GHR unchanged.
  - If both flags are set, req_is_jmp takes priority.
- No accepted request: pred_valid=0 next cycle; pred_taken and pred_ghr hold their values.
- Update (RUN, upd_valid=1):
  - table[idx_u] increments if upd_taken and decrements otherwise, saturating at 0 and 2^CTR_BITS-1.
  - perf_br increments; perf_miss increments if upd_mispredict. Both saturate at all-ones.
- Mispredict recovery: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}. This overrides any speculative shift in the same cycle; none occurs, because req_ready=0.
- Same-cycle predict and update to the same index: the read returns the pre-update value; the write lands at the clock edge.
- One table write port. The sweep and updates are mutually exclusive by FSM state.
- Reset mid-sweep or mid-RUN restarts the sweep from 0. Any outstanding prediction is discarded (pred_valid=0).

Test Plan:
- Reset, then hold rst=1 with defaults -> init_done=0 for exactly 256 cycles, then 1; req_ready rises in the same cycle; first branch at pc=0x100 yields pred_taken=0, pred_ghr=0.
- Two updates taken=1 at pc=0x100, upd_ghr=0 -> counter 01→10→11; predict pc=0x100 with GHR forced 0 via mispredict recovery (upd_ghr=0x00, taken=0 elsewhere) -> pred_taken=1. Four not-taken updates -> counter saturates at 00.
- Speculative history: three branches predicted taken from GHR=0x00 -> pred_ghr values 0x00, 0x01, 0x03; then a mispredict with upd_ghr=0x01, upd_taken=0 -> GHR=0x02; req_ready=0 in that cycle.
- Jump and non-branch: req_is_jmp=1 -> pred_taken=1, GHR unchanged; neither flag -> pred_taken=0, GHR unchanged.
- PERF_W=4: drive 20 mispredicted updates -> perf_br=perf_miss=15 (held at saturation).
- Assert rst=0 mid-sweep at index 100 and again in RUN with pred_valid=1 -> all outputs at reset values immediately; sweep restarts and takes a full 256 cycles.
